// File: rtl/multi_chan_disp_pkg.sv
// Shared constants and helpers for the multi-channel display selector:
// channel-0 reset pattern, bit-width helper and scan-mode encoding.
package multi_chan_disp_pkg;

    localparam logic [31:0] CH0_RST_WORD = 32'hAA55_55AA;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } scan_mode_e;

    // Bits needed to index v distinct values, never less than 1.
    function automatic int clog2_int(input int v);
        int w;
        w = 1;
        while ((1 << w) < v) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/multi_chan_disp_scan_ctrl.sv
// Channel scan controller: tracks the current channel, either following the
// manual select or stepping through the masked channels after each dwell.
module disp_scan_ctrl
    import multi_chan_disp_pkg::*;
#(
    parameter int NCH   = 8,
    parameter int DWELL = 50_000_000,
    localparam int CW   = clog2_int(NCH),
    localparam int CNTW = clog2_int(DWELL)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           auto_en,
    input  logic [NCH-1:0] chan_mask,
    input  logic [CW-1:0]  test_ch,
    output logic [CW-1:0]  cur_ch
);

    localparam logic [CNTW-1:0] LAST = CNTW'(DWELL - 1);

    scan_mode_e      mode;
    logic [CNTW-1:0] dwell_cnt;
    logic [CW-1:0]   next_ch;
    logic [CW-1:0]   cand;
    logic            found;

    assign mode = auto_en ? MODE_AUTO : MODE_MANUAL;

    // Next higher enabled channel, wrapping; falls back to cur_ch itself
    // when it is the only enabled one.
    always_comb begin
        next_ch = cur_ch;
        cand    = cur_ch;
        found   = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            cand = cur_ch + CW'(i);
            if (!found && chan_mask[cand]) begin
                next_ch = cand;
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_ch    <= '0;
            dwell_cnt <= '0;
        end else if (mode == MODE_MANUAL) begin
            // Counter parked at zero so a switch to auto starts a fresh dwell.
            cur_ch    <= test_ch;
            dwell_cnt <= '0;
        end else if (chan_mask == '0) begin
            cur_ch    <= '0;
            dwell_cnt <= '0;
        end else if (!chan_mask[cur_ch] || (dwell_cnt == LAST)) begin
            cur_ch    <= next_ch;
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multi_chan_disp.sv
// Multi-channel display selector: CPU-written channel 0 plus externally fed
// channels, muxed by manual select or auto-scan into registered outputs.
module multi_chan_disp
    import multi_chan_disp_pkg::*;
#(
    parameter int NCH   = 8,
    parameter int DW    = 32,
    parameter int DWELL = 50_000_000,
    localparam int ND   = DW / 4,
    localparam int NB   = DW / 8,
    localparam int CW   = clog2_int(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NB-1:0]     EN,
    input  logic [DW-1:0]     Data0,
    input  logic [ND*NCH-1:0] LES,
    input  logic [ND*NCH-1:0] point_in,
    input  logic [DW*NCH-1:0] data_in,
    input  logic [CW-1:0]     Test,
    input  logic              auto_en,
    input  logic [NCH-1:0]    chan_mask,
    output logic [DW-1:0]     Disp_num,
    output logic [ND-1:0]     LE_out,
    output logic [ND-1:0]     point_out,
    output logic [CW-1:0]     chan_out,
    output logic              chan_chg
);

    // Reset word is the 32-bit pattern repeated byte-for-byte across DW.
    function automatic logic [DW-1:0] disp_reset_word();
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < NB; k++) begin
            w[8*k +: 8] = CH0_RST_WORD[8*(k % 4) +: 8];
        end
        return w;
    endfunction

    localparam logic [DW-1:0] DISP_RST = disp_reset_word();

    logic [DW-1:0] disp_data;
    logic [ND-1:0] cpu_blink;
    logic [ND-1:0] cpu_point;
    logic [CW-1:0] cur_ch;
    logic [CW-1:0] sel_ch;
    logic [DW-1:0] sel_word;
    logic [ND-1:0] sel_blink;
    logic [ND-1:0] sel_point;

    disp_scan_ctrl #(
        .NCH   (NCH),
        .DWELL (DWELL)
    ) u_scan (
        .clk       (clk),
        .rst_n     (rst),
        .auto_en   (auto_en),
        .chan_mask (chan_mask),
        .test_ch   (Test),
        .cur_ch    (cur_ch)
    );

    // Each byte lane owns one data byte and the two digits it displays.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_data <= DISP_RST;
            cpu_blink <= '1;
            cpu_point <= '0;
        end else begin
            for (int k = 0; k < NB; k++) begin
                if (EN[k]) begin
                    disp_data[8*k +: 8] <= Data0[8*k +: 8];
                    cpu_blink[2*k +: 2] <= LES[2*k +: 2];
                    cpu_point[2*k +: 2] <= point_in[2*k +: 2];
                end
            end
        end
    end

    // Manual select bypasses the scan register so a Test change lands in one cycle.
    assign sel_ch = auto_en ? cur_ch : Test;

    always_comb begin
        sel_word  = data_in[int'(sel_ch)*DW +: DW];
        sel_blink = LES[int'(sel_ch)*ND +: ND];
        sel_point = point_in[int'(sel_ch)*ND +: ND];
        if (sel_ch == '0) begin
            sel_word  = disp_data;
            sel_blink = cpu_blink;
            sel_point = cpu_point;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Disp_num  <= '0;
            LE_out    <= '0;
            point_out <= '0;
            chan_out  <= '0;
            chan_chg  <= 1'b0;
        end else begin
            Disp_num  <= sel_word;
            LE_out    <= sel_blink;
            point_out <= sel_point;
            chan_out  <= sel_ch;
            chan_chg  <= (sel_ch != chan_out);
        end
    end

endmodule
